// File: rtl/icache.sv
// Direct-mapped, one-word-per-set instruction cache with a two-state miss-fill FSM.
// Optional macro ICACHE_FILL_BYPASS_EN forwards iload to the requester in the completing fill cycle.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q;
    logic [SETS-1:0]   valid_q;
    logic [29:0]       miss_q;
    logic              iren_q;
    logic [31:0]       iaddr_q;
    logic [TAGW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX-1:0]    req_idx;
    logic [TAGW-1:0]   req_tag;
    logic [IDX-1:0]    miss_idx;
    logic [TAGW-1:0]   miss_tag;
    logic              lookup_hit;
    logic              fill_we;
    logic              bypass_hit;
    logic [1:0]        unused_offset;

    assign unused_offset = imemaddr[1:0];
    assign req_idx  = imemaddr[IDX+1:2];
    assign req_tag  = imemaddr[31:IDX+2];
    assign miss_idx = miss_q[IDX-1:0];
    assign miss_tag = miss_q[29:IDX];

    // Lookups only count in IDLE; a fill in flight owns the arrays.
    assign lookup_hit = !RST && (state_q == IDLE) && imemREN && valid_q[req_idx]
                        && (tag_q[req_idx] == req_tag);
    assign fill_we    = !RST && (state_q == FETCH) && !iwait;

`ifdef ICACHE_FILL_BYPASS_EN
    assign bypass_hit = fill_we && imemREN && (imemaddr[31:2] == miss_q);
`else
    assign bypass_hit = 1'b0;
`endif

    assign ihit     = lookup_hit | bypass_hit;
    assign imemload = lookup_hit ? data_q[req_idx] : (bypass_hit ? iload : 32'h0);
    assign iREN     = iren_q;
    assign iaddr    = iaddr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= '0;
            miss_q  <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !lookup_hit) begin
                        miss_q  <= imemaddr[31:2];
                        iren_q  <= 1'b1;
                        iaddr_q <= {imemaddr[31:2], 2'b00};
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        iren_q  <= 1'b0;
                        iaddr_q <= 32'h0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, single-word-block instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. Serves `imemREN`/`imemaddr` requests with a same-cycle `ihit`/`imemload` on a hit. On a miss, runs a two-state fill FSM against the controller's `iREN`/`iaddr`/`iwait`/`iload` handshake. Reads only; never writes back.

## Interface
- `SETS`, default 16: number of sets; power of two, 2..1024. `IDX = log2(SETS)`, tag width `30 - IDX`.
- `CLK  in  1`: clock, rising edge.
- `RST  in  1`: reset; synchronous, active-high.
- `imemREN  in  1`: datapath instruction read request.
- `imemaddr  in  32`: datapath fetch address; bits [1:0] ignored.
- `ihit  out  1`: `imemload` valid for current `imemaddr` this cycle.
- `imemload  out  32`: instruction word.
- `iREN  out  1`: read request to memory controller.
- `iaddr  out  32`: word-aligned fill address to memory controller.
- `iwait  in  1`: controller busy; `iload` valid in a cycle where `iREN=1` and `iwait=0`.
- `iload  in  32`: fill data from controller.

## Operation
- Address split: offset [1:0] ignored; index = `imemaddr[IDX+1:2]`; tag = `imemaddr[31:IDX+2]`.
- Storage per set: valid bit, tag, 32-bit data word. Valid bits are cleared by reset. Tag and data arrays are not reset.
- Hit (combinational): `hit = imemREN && valid[index] && tag[index]==tag`. `ihit=hit`; `imemload = hit ? data[index] : 0`.
- FSM states: IDLE, FETCH.
  - IDLE: `iREN=0`, `iaddr=0`. If `imemREN && !hit`, latch `miss_addr <= {imemaddr[31:2],2'b00}` and go to FETCH.
  - FETCH: `iREN=1`, `iaddr=miss_addr`, and `ihit` is forced to 0, except as allowed under Configuration. If `iwait=0`: write `data[miss idx] <= iload`, `tag <= miss tag`, `valid <= 1`, then go to IDLE. Otherwise stay in FETCH.
- Fill always targets `miss_addr`, never the live `imemaddr`.
- `imemREN` dropping or `imemaddr` changing during FETCH does not abort the fill. The fill completes normally.
- Fill overwrites the set unconditionally (conflict eviction).
- Reset asserted in any state, including mid-FETCH:
  - next state IDLE;
  - all valid bits cleared;
  - `miss_addr` cleared to 0;
  - an in-flight fill is discarded and no array write occurs that cycle.
- Reset values: `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`.

## Timing
- Hit latency: 0 cycles. `ihit`/`imemload` are combinational from `imemaddr` in IDLE.
- Miss sequence:
  - cycle t: miss detected in IDLE;
  - cycle t+1: `iREN=1`;
  - cycle t+k (k≥1): first cycle with `iwait=0`; arrays are written at the end of this cycle;
  - cycle t+k+1: IDLE, `ihit=1` if the request still targets the filled address.
- Minimum miss penalty is 2 cycles (t → t+2 hit).
- `iREN` stays high continuously from entering FETCH until the edge ending the `iwait=0` cycle. It is never high in IDLE.
- A new miss may be detected in the first IDLE cycle after a fill. No back-to-back FETCH without an intervening IDLE cycle.
- A hit and a fill to the same set in the same cycle cannot occur, because `ihit` is 0 in FETCH.

## Configuration
- `ICACHE_FILL_BYPASS_EN` defined: in the FETCH cycle with `iwait=0`, if `imemREN=1` and `imemaddr[31:2]==miss_addr[31:2]`, then `ihit=1` and `imemload=iload`. This saves one cycle, so the minimum miss penalty is 1.
- `ICACHE_FILL_BYPASS_EN` undefined: `ihit=0` throughout FETCH. The requester hits in the following IDLE cycle.

## Test plan
- Reset with `imemREN=1`, `imemaddr=0x0`: during reset `ihit=0`, `iREN=0`. The first cycle after reset is a miss, and `iREN` rises the next cycle with `iaddr=0x0`.
- Cold miss at `0x0000_0104` with `iwait` high for 3 FETCH cycles, then low with `iload=0x2008_0001`:
  - `iREN` is high for exactly 4 cycles with `iaddr=0x104`;
  - the next cycle has `ihit=1`, `imemload=0x2008_0001` (with bypass: in the `iwait=0` cycle).
- After filling `0x00` and `0x04`, re-request each: `ihit=1` in the same cycle, `iREN` stays 0, and the loaded words are returned.
- Conflict with SETS=16: fill `0x000`, then request `0x040`, which has the same index. Result: miss, then fill. Re-request `0x000`: miss again, and `iaddr=0x000`.
- `imemREN=0` with an arbitrary address: `ihit=0`, `imemload=0`, and `iREN` is never asserted. Drop `imemREN` mid-FETCH: the fill still completes, and a later request hits.
- Assert `RST` for one cycle mid-FETCH (`iwait=1`):
  - next cycle `iREN=0`;
  - the earlier-filled `0x04` now misses;
  - the interrupted address is not valid.
